// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, states, mux codes
// and the control-word layout.
package mips_mc_pkg;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_ADDI  = 3'd1;
    localparam logic [2:0] OP_LW    = 3'd2;
    localparam logic [2:0] OP_SW    = 3'd3;
    localparam logic [2:0] OP_BEQ   = 3'd4;
    localparam logic [2:0] OP_J     = 3'd5;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_ADDI_EX  = 4'd8,
        S_ADDI_WB  = 4'd9,
        S_BEQ_EX   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_BR  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
    } ctrl_t;

    // States in which an instruction retires.
    function automatic logic is_terminal(state_e s);
        return s inside {S_MEMWB, S_MEMWR, S_RTYPE_WB, S_ADDI_WB, S_BEQ_EX, S_JUMP};
    endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mips_mc_control_if #(parameter int COUNT_W = 16);
    logic [2:0]         OpCode;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               IorD;
    logic               MemRD;
    logic               MemWR;
    logic               IRWrite;
    logic               MemToReg;
    logic               RegDst;
    logic               RegWR;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic [1:0]         PCSource;
    logic [3:0]         StateOut;
    logic [COUNT_W-1:0] InstrCount;
    logic               Halted;

    modport master (
        input  OpCode,
        output PCWrite, PCWriteCond, IorD, MemRD, MemWR, IRWrite, MemToReg, RegDst,
               RegWR, ALUSrcA, ALUSrcB, ALUOp, PCSource, StateOut, InstrCount, Halted
    );

    modport slave (
        output OpCode,
        input  PCWrite, PCWriteCond, IorD, MemRD, MemWR, IRWrite, MemToReg, RegDst,
               RegWR, ALUSrcA, ALUSrcB, ALUOp, PCSource, StateOut, InstrCount, Halted
    );
endinterface

// File: rtl/mips_mc_ctrl_decode.sv
// Combinational state -> control-word map (Moore outputs).
// Halted is only ever raised when MIPS_MC_ILLEGAL_TRAP_EN is defined.
module mips_mc_ctrl_decode
    import mips_mc_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_rd    = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_ONE;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.pc_write  = 1'b1;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_BR;
            S_MEMADR, S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_rd = 1'b1;
                ctrl_o.iord   = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_wr = 1'b1;
                ctrl_o.iord   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_wr     = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl_o.reg_dst = 1'b1;
                ctrl_o.reg_wr  = 1'b1;
            end
            S_ADDI_WB: ctrl_o.reg_wr = 1'b1;
            S_BEQ_EX: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            S_TRAP: ctrl_o.halted = 1'b1;
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Moore control FSM for the 16-bit multicycle MIPS datapath, with retired-instruction counter.
// Define MIPS_MC_ILLEGAL_TRAP_EN to halt in TRAP on illegal opcodes instead of skipping them.
//
// state      | meaning
// FETCH      | read instr, load IR, PC += 1
// DECODE     | read regs, precompute branch target
// MEMADR     | LW/SW address calc
// MEMRD/MEMWB| load read / load writeback
// MEMWR      | store write
// *_EX/*_WB  | RTYPE/ADDI execute / writeback
// BEQ_EX     | branch compare and conditional PC load
// JUMP       | jump PC load
// TRAP       | halted on illegal opcode until Reset
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic          Clock,
    input  logic          Reset,
    mips_mc_control_if.master bus
);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    ctrl_t              ctrl;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (bus.OpCode)
                    OP_RTYPE:      state_d = S_RTYPE_EX;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BEQ_EX;
                    OP_J:          state_d = S_JUMP;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                    default:       state_d = S_TRAP;
`else
                    default:       state_d = S_FETCH;
`endif
                endcase
            end
            // IR is held (IRWrite=0), so OpCode is still this instruction's.
            S_MEMADR:   state_d = (bus.OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    assign count_d = is_terminal(state_q) ? count_q + 1'b1 : count_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    mips_mc_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    // Enables are gated by Reset so no negedge write lands while the state is being reset.
    assign bus.PCWrite     = ctrl.pc_write      & ~Reset;
    assign bus.PCWriteCond = ctrl.pc_write_cond & ~Reset;
    assign bus.MemRD       = ctrl.mem_rd        & ~Reset;
    assign bus.MemWR       = ctrl.mem_wr        & ~Reset;
    assign bus.IRWrite     = ctrl.ir_write      & ~Reset;
    assign bus.RegWR       = ctrl.reg_wr        & ~Reset;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemToReg    = ctrl.mem_to_reg;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.Halted      = ctrl.halted;
    assign bus.StateOut    = state_q;
    assign bus.InstrCount  = count_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: per-cycle expected state/controls/count queued
// per instruction, then compared each cycle in the low clock phase.
module tb_mips_mc_control;

    localparam int CW = 4;
    localparam logic [16:0] EN_MASK = 17'b11011100100000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_mc_control_if #(.COUNT_W(CW)) bus();

    mips_mc_control #(.COUNT_W(CW)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus.master)
    );

    logic [16:0] obs;
    assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRD, bus.MemWR, bus.IRWrite,
                  bus.MemToReg, bus.RegDst, bus.RegWR, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.PCSource, bus.Halted};

    typedef struct {
        int          st;
        logic [16:0] cw;
        int          cnt;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cnt = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] exp_ctrl(int st);
        logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, halt;
        logic [1:0] srcb, aop, pcs;
        {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, halt} = '0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            0:    begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
            1:    srcb = 2'b11;
            2, 8: begin srca = 1; srcb = 2'b10; end
            3:    begin mrd = 1; iord = 1; end
            4:    begin m2r = 1; rwr = 1; end
            5:    begin mwr = 1; iord = 1; end
            6:    begin srca = 1; aop = 2'b10; end
            7:    begin rdst = 1; rwr = 1; end
            9:    rwr = 1;
            10:   begin srca = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
            11:   begin pcw = 1; pcs = 2'b10; end
            12:   halt = 1;
            default: ;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, pcs, halt};
    endfunction

    task automatic push(int st, string tag);
        exp_t e;
        e.st  = st;
        e.cw  = exp_ctrl(st);
        e.cnt = m_cnt;
        e.tag = tag;
        sb.push_back(e);
        if (st inside {4, 5, 7, 9, 10, 11}) m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ":state"}, 32'(bus.StateOut), e.st);
            chk({e.tag, ":ctrl"}, 32'(obs), 32'(e.cw));
            chk({e.tag, ":count"}, 32'(bus.InstrCount), e.cnt);
            @(negedge clk); #1;
        end
    endtask

    task automatic run_instr(int op, string tag);
        bus.OpCode = op[2:0];
        push(0, tag);
        push(1, tag);
        case (op)
            0: begin push(6, tag); push(7, tag); end
            1: begin push(8, tag); push(9, tag); end
            2: begin push(2, tag); push(3, tag); push(4, tag); end
            3: begin push(2, tag); push(5, tag); end
            4: push(10, tag);
            5: push(11, tag);
            default: begin
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
                repeat (10) push(12, tag);
`endif
            end
        endcase
        drain();
    endtask

    task automatic apply_reset(int n, string tag);
        rst = 1'b1;
        #1;
        chk({tag, ":gated_now"}, 32'(obs & EN_MASK), 0);
        repeat (n) begin
            @(negedge clk); #1;
            chk({tag, ":rst_state"}, 32'(bus.StateOut), 0);
            chk({tag, ":rst_count"}, 32'(bus.InstrCount), 0);
            chk({tag, ":rst_ctrl"}, 32'(obs), 32'(exp_ctrl(0) & ~EN_MASK));
        end
        rst = 1'b0;
        m_cnt = 0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bus.OpCode = 3'd0;
        #1;
        apply_reset(3, "por");

        run_instr(2, "lw");
        run_instr(3, "sw");
        run_instr(0, "rtype");
        run_instr(1, "addi");
        run_instr(4, "beq");
        run_instr(5, "j");
        run_instr(6, "illegal");
`ifdef MIPS_MC_ILLEGAL_TRAP_EN
        apply_reset(2, "trap_rec");
`else
        run_instr(7, "illegal7");
`endif
        run_instr(1, "after_ill");

        apply_reset(1, "pre_wrap");
        for (int i = 0; i < 16; i++) run_instr(0, "wrap_rt");
        chk("wrap_zero", 32'(bus.InstrCount), 0);

        bus.OpCode = 3'd0;
        push(0, "abort");
        push(1, "abort");
        drain();
        chk("abort_in_ex", 32'(bus.StateOut), 6);
        apply_reset(1, "abort_rst");
        chk("abort_regwr", 32'(bus.RegWR), 0);
        push(0, "post_abort");
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
